// File: rtl/alu_ops_pkg.sv
// Shared funct codes, FSM states and decode helpers for the bit-serial ALU sequencer.
package alu_ops_pkg;

  localparam int unsigned FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {StIdle, StRun, StSltFix, StDone} state_e;

  typedef enum logic [1:0] {SliceAnd, SliceOr, SliceAdd} slice_op_e;

  function automatic logic is_legal_op(input logic [FUNCT_W-1:0] funct);
    return (funct == FUNCT_AND) || (funct == FUNCT_OR) || (funct == FUNCT_ADD) ||
           (funct == FUNCT_SUB) || (funct == FUNCT_SLT);
  endfunction

  // SUB and SLT both compute A + ~B + 1.
  function automatic logic op_inverts(input logic [FUNCT_W-1:0] funct);
    return (funct == FUNCT_SUB) || (funct == FUNCT_SLT);
  endfunction

  function automatic slice_op_e slice_op(input logic [FUNCT_W-1:0] funct);
    slice_op_e op;
    if (funct == FUNCT_AND) begin
      op = SliceAnd;
    end else if (funct == FUNCT_OR) begin
      op = SliceOr;
    end else begin
      op = SliceAdd;
    end
    return op;
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: AND, OR or full-adder sum, with optional B inversion.
module alu_bit_slice
  import alu_ops_pkg::*;
(
  input  logic      a,
  input  logic      b,
  input  logic      c_in,
  input  logic      invert,
  input  slice_op_e op,
  output logic      result,
  output logic      c_out
);

  logic b_eff;

  always_comb begin
    b_eff  = b ^ invert;
    c_out  = (a & b_eff) | (c_in & (a ^ b_eff));
    result = 1'b0;
    unique case (op)
      SliceAnd: result = a & b_eff;
      SliceOr:  result = a | b_eff;
      default:  result = a ^ b_eff ^ c_in;
    endcase
  end

endmodule

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU: walks one alu_bit_slice across WIDTH cycles for AND/OR/ADD/SUB/SLT,
// with SLT finalised from the MSB sum and overflow.
module alu_serial_sequencer
  import alu_ops_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  input  logic [FUNCT_W-1:0] Signal,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WIDTH-1:0]   dataOut
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [WIDTH-1:0]     data_out_q, data_out_d;
  logic [FUNCT_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 carry_q, carry_d;
  logic                 c_in_msb_q, c_in_msb_d;
  logic                 sum_msb_q, sum_msb_d;
  logic                 err_q, err_d;
  logic                 slice_out, slice_cout, less;

  alu_bit_slice u_slice (
    .a      (a_q[cnt_q]),
    .b      (b_q[cnt_q]),
    .c_in   (carry_q),
    .invert (op_inverts(op_q)),
    .op     (slice_op(op_q)),
    .result (slice_out),
    .c_out  (slice_cout)
  );

  // In SltFix carry_q holds the carry out of the MSB.
  assign less = sum_msb_q ^ (c_in_msb_q ^ carry_q);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    res_d      = res_q;
    c_in_msb_d = c_in_msb_q;
    sum_msb_d  = sum_msb_q;
    data_out_d = data_out_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = dataA;
          b_d     = dataB;
          op_d    = Signal;
          cnt_d   = '0;
          carry_d = op_inverts(Signal);
          res_d   = '0;
          if (is_legal_op(Signal)) begin
            err_d   = 1'b0;
            state_d = StRun;
          end else begin
            err_d      = 1'b1;
            data_out_d = '0;
            state_d    = StDone;
          end
        end
      end
      StRun: begin
        res_d[cnt_q] = slice_out;
        carry_d      = slice_cout;
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == CntLast) begin
          c_in_msb_d = carry_q;
          sum_msb_d  = slice_out;
          if (op_q == FUNCT_SLT) begin
            state_d = StSltFix;
          end else begin
            data_out_d = res_d;
            state_d    = StDone;
          end
        end
      end
      StSltFix: begin
        res_d      = {{(WIDTH-1){1'b0}}, less};
        data_out_d = res_d;
        state_d    = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      res_q      <= '0;
      c_in_msb_q <= 1'b0;
      sum_msb_q  <= 1'b0;
      data_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      res_q      <= res_d;
      c_in_msb_q <= c_in_msb_d;
      sum_msb_q  <= sum_msb_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
    end
  end

  assign busy    = (state_q == StRun) || (state_q == StSltFix);
  assign done    = (state_q == StDone);
  assign err     = done & err_q;
  assign dataOut = data_out_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed bench for alu_serial_sequencer: latency, results, handshake and reset abort.
module tb_alu_serial_sequencer;

  localparam int unsigned W = 32;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLT = 6'b101010;

  logic         clk, reset, start, busy, done, err;
  logic [W-1:0] dataA, dataB, dataOut;
  logic [5:0]   Signal;

  int errors = 0;
  int checks = 0;

  alu_serial_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .dataOut (dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents a request for one edge; returns at the first negedge after acceptance (k=1).
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] sig);
    @(negedge clk);
    dataA  = a;
    dataB  = b;
    Signal = sig;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges since the accepting edge until done; -1 on timeout.
  task automatic wait_done(input int k0, output int lat, output bit saw_busy);
    lat      = k0;
    saw_busy = (busy === 1'b1);
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    dataA = '0;
    dataB = '0;
    Signal = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || dataOut !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b err=%b dataOut=%h, required 0 0 0 0",
               busy, done, err, dataOut);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_add();
    int lat;
    bit sb;
    launch(32'h7FFF_FFFF, 32'h0000_0001, F_ADD);
    wait_done(1, lat, sb);
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL add_latency: got %0d, required 33", lat);
    end
    checks++;
    if (dataOut !== 32'h8000_0000 || err !== 1'b0) begin
      errors++;
      $display("FAIL add_result: dataOut=%h err=%b, required 80000000 0", dataOut, err);
    end
    checks++;
    if (!sb) begin
      errors++;
      $display("FAIL add_busy: busy never seen high, required high during RUN");
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL add_done_pulse: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_sub_slt();
    int lat;
    bit sb;
    launch(32'd5, 32'd7, F_SUB);
    wait_done(1, lat, sb);
    checks++;
    if (lat !== 33 || dataOut !== 32'hFFFF_FFFE || err !== 1'b0) begin
      errors++;
      $display("FAIL sub: lat=%0d dataOut=%h err=%b, required 33 FFFFFFFE 0", lat, dataOut, err);
    end
    launch(32'h8000_0000, 32'h0000_0001, F_SLT);
    wait_done(1, lat, sb);
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("FAIL slt_latency: got %0d, required 34", lat);
    end
    checks++;
    if (dataOut !== 32'h0000_0001 || err !== 1'b0) begin
      errors++;
      $display("FAIL slt_overflow: dataOut=%h err=%b, required 00000001 0", dataOut, err);
    end
    // 3 < 2 is false: result must clear.
    launch(32'd3, 32'd2, F_SLT);
    wait_done(1, lat, sb);
    checks++;
    if (lat !== 34 || dataOut !== 32'h0000_0000) begin
      errors++;
      $display("FAIL slt_false: lat=%0d dataOut=%h, required 34 00000000", lat, dataOut);
    end
  endtask

  task automatic test_and_or();
    int lat;
    bit sb;
    launch(32'hF0F0_F0F0, 32'hFF00_FF00, F_AND);
    wait_done(1, lat, sb);
    checks++;
    if (lat !== 33 || dataOut !== 32'hF000_F000) begin
      errors++;
      $display("FAIL and: lat=%0d dataOut=%h, required 33 F000F000", lat, dataOut);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (dataOut !== 32'hF000_F000) begin
      errors++;
      $display("FAIL and_hold_idle: dataOut=%h, required F000F000", dataOut);
    end
    launch(32'hF0F0_F0F0, 32'hFF00_FF00, F_OR);
    repeat (9) @(negedge clk);
    checks++;
    if (dataOut !== 32'hF000_F000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL and_hold_run: dataOut=%h busy=%b, required F000F000 1", dataOut, busy);
    end
    wait_done(10, lat, sb);
    checks++;
    if (lat !== 33 || dataOut !== 32'hFFF0_FFF0) begin
      errors++;
      $display("FAIL or: lat=%0d dataOut=%h, required 33 FFF0FFF0", lat, dataOut);
    end
  endtask

  task automatic test_illegal();
    int lat;
    bit sb;
    launch(32'h1234_5678, 32'h1111_1111, 6'b000000);
    wait_done(1, lat, sb);
    checks++;
    if (lat !== 1 || err !== 1'b1 || dataOut !== '0) begin
      errors++;
      $display("FAIL illegal: lat=%0d err=%b dataOut=%h, required 1 1 00000000", lat, err, dataOut);
    end
    checks++;
    if (sb) begin
      errors++;
      $display("FAIL illegal_busy: busy seen high, required never");
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_after: done=%b err=%b busy=%b, required 0 0 0", done, err, busy);
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    bit sb;
    launch(32'h0000_1234, 32'h0000_1111, F_ADD);
    repeat (9) @(negedge clk);
    // k=10: a competing request with different operands, plus a lasting dataA change.
    dataA  = 32'hDEAD_BEEF;
    dataB  = 32'h0F0F_0F0F;
    Signal = F_AND;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(11, lat, sb);
    checks++;
    if (lat !== 33 || dataOut !== 32'h0000_2345) begin
      errors++;
      $display("FAIL busy_start_ignored: lat=%0d dataOut=%h, required 33 00002345", lat, dataOut);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_not_queued: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    bit sb;
    bit saw_done;
    launch(32'h0000_00FF, 32'h0000_0001, F_ADD);
    saw_done = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dataOut !== '0 || saw_done) begin
      errors++;
      $display("FAIL reset_abort: busy=%b done=%b dataOut=%h early_done=%b, required 0 0 0 0",
               busy, done, dataOut, saw_done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    launch(32'd3, 32'd4, F_ADD);
    wait_done(1, lat, sb);
    checks++;
    if (lat !== 33 || dataOut !== 32'd7) begin
      errors++;
      $display("FAIL add_after_reset: lat=%0d dataOut=%h, required 33 00000007", lat, dataOut);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    bit idle_seen;
    @(negedge clk);
    dataA  = 32'hF0F0_F0F0;
    dataB  = 32'hFF00_FF00;
    Signal = F_OR;
    start  = 1'b1;
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== 33 || dataOut !== 32'hFFF0_FFF0) begin
      errors++;
      $display("FAIL b2b_first: k=%0d dataOut=%h, required 33 FFF0FFF0", k, dataOut);
    end
    Signal = F_AND;
    @(negedge clk);
    k++;
    idle_seen = (busy === 1'b0 && done === 1'b0);
    while (done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    checks++;
    if (k !== 67 || dataOut !== 32'hF000_F000 || !idle_seen) begin
      errors++;
      $display("FAIL b2b_second: k=%0d dataOut=%h idle_gap=%b, required 67 F000F000 1",
               k, dataOut, idle_seen);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_and_or();
    test_illegal();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
